mod_sub_serial: RTL and testbench



---
 rtl/ecc_pkg.sv | 7 +
 rtl/limb_addsub.sv | 17 +
 rtl/mod_sub_serial.sv | 78 +++++++
 tb/tb_mod_sub_serial.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: secp256k1 field constants and the controller state encoding shared by the field units.
package ecc_pkg;
    localparam int FIELD_W = 256;
    localparam logic [FIELD_W-1:0] P_CONST =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} ecc_state_t;
endpackage

// File: rtl/limb_addsub.sv
// limb_addsub: one W-bit adder/subtractor; o_cout is the carry (add) or borrow (sub) out.
module limb_addsub #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    input  logic         i_cin,
    output logic [W-1:0] o_y,
    output logic         o_cout
);
    logic [W:0] w_a, w_b, w_c;
    assign w_a = {1'b0, i_a};
    assign w_b = {1'b0, i_b};
    assign w_c = (W+1)'(i_cin);
    assign {o_cout, o_y} = i_sub ? w_a - w_b - w_c : w_a + w_b + w_c;
endmodule

// File: rtl/mod_sub_serial.sv
// mod_sub_serial: limb-serial R = (A - B) mod p; subtract pass, then an add-p pass only on final borrow.
module mod_sub_serial
    import ecc_pkg::*;
#(
    parameter int                 LIMB_W  = 32,
    parameter logic [FIELD_W-1:0] P_CONST = ecc_pkg::P_CONST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FIELD_W-1:0] A,
    input  logic [FIELD_W-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [FIELD_W-1:0] R
);
    localparam int N_LIMBS = FIELD_W / LIMB_W;
    localparam int IDX_W   = N_LIMBS > 1 ? $clog2(N_LIMBS) : 1;

    ecc_state_t         r_state, w_next;
    logic [FIELD_W-1:0] r_a, r_b, r_r;
    logic [IDX_W-1:0]   r_idx;
    logic               r_cb;
    logic [LIMB_W-1:0]  w_op_a, w_op_b, w_y;
    logic               w_cout, w_last, w_fix;

    assign w_fix  = r_state == FIX;
    assign w_last = r_idx == IDX_W'(N_LIMBS - 1);
    // FIX reuses the same limb unit on the partial result and the prime
    assign w_op_a = w_fix ? r_r[r_idx*LIMB_W +: LIMB_W] : r_a[r_idx*LIMB_W +: LIMB_W];
    assign w_op_b = w_fix ? P_CONST[r_idx*LIMB_W +: LIMB_W] : r_b[r_idx*LIMB_W +: LIMB_W];

    limb_addsub #(.W(LIMB_W)) u_limb (
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .i_sub (!w_fix),
        .i_cin (r_cb),
        .o_y   (w_y),
        .o_cout(w_cout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? SUB : IDLE;
            SUB:     w_next = w_last ? (w_cout ? FIX : DONE) : SUB;
            FIX:     w_next = w_last ? DONE : FIX;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_idx   <= '0;
            r_cb    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_a   <= A;
                r_b   <= B;
                r_idx <= '0;
                r_cb  <= 1'b0;
            end else if (r_state == SUB || w_fix) begin
                r_r[r_idx*LIMB_W +: LIMB_W] <= w_y;
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                r_cb  <= w_last ? 1'b0 : w_cout;
            end
        end
    end

    assign busy = r_state == SUB || w_fix;
    assign done = r_state == DONE;
    assign R    = r_r;
endmodule

// File: tb/tb_mod_sub_serial.sv
// tb_mod_sub_serial: directed vector table plus handshake/reset sequences and a random regression.
module tb_mod_sub_serial;
    localparam logic [255:0] P   = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] PM1 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2E;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [255:0] A = '0, B = '0;
    logic         busy, done;
    logic [255:0] R;
    int           checks = 0, failures = 0;

    mod_sub_serial dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .R    (R)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] a, b, r;
        int           lat;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_fe();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v >= P ? v - P : v;
    endfunction

    // Cycle 1 is the first cycle after the accepting edge; operands are scrambled after capture.
    task automatic run_op(input logic [255:0] a, input logic [255:0] b,
                          output logic [255:0] res, output int lat, output logic hs_ok);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = rand_fe(); B = rand_fe();
        lat = 0; res = 'x; hs_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat = c; res = R; hs_ok &= !busy;
                break;
            end
            hs_ok &= busy;
            @(negedge clk);
        end
        @(negedge clk);
        hs_ok &= !done && !busy;
    endtask

    logic [255:0] res, ra, rb, golden;
    int           lat, ndone, first_done, second_done;
    logic         hs_ok;

    initial begin
        vecs[0] = '{256'd5, 256'd3, 256'd2, 9};
        vecs[1] = '{256'd1, 256'd2, PM1, 17};
        vecs[2] = '{256'd0, 256'd0, 256'd0, 9};
        vecs[3] = '{PM1, PM1, 256'd0, 9};
        vecs[4] = '{256'd0, PM1, 256'd1, 17};
        vecs[5] = '{256'h11110, 256'hFEDC, 256'h1234, 9};
        vecs[6] = '{256'h1_0000_0000, 256'd1, 256'hFFFF_FFFF, 9};
        vecs[7] = '{256'd3, 256'd5, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D, 17};

        repeat (2) @(negedge clk);
        check("reset_busy", 256'(busy), 256'd0);
        check("reset_done", 256'(done), 256'd0);
        check("reset_R", R, 256'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, res, lat, hs_ok);
            check($sformatf("vec%0d_R", i), res, vecs[i].r);
            check($sformatf("vec%0d_lat", i), 256'(lat), 256'(vecs[i].lat));
            check($sformatf("vec%0d_handshake", i), 256'(hs_ok), 256'd1);
        end

        // start with new operands while busy must be ignored
        @(negedge clk);
        A = 256'd1; B = 256'd2; start = 1'b1;
        ndone = 0; first_done = 0; res = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c >= 2 && c <= 4);
            if (start) begin A = 256'd9; B = 256'd4; end
            if (done) begin
                ndone++;
                if (first_done == 0) begin first_done = c; res = R; end
            end
        end
        check("busy_start_ndone", 256'(ndone), 256'd1);
        check("busy_start_lat", 256'(first_done), 256'd17);
        check("busy_start_R", res, PM1);

        // start held high: the re-accept happens in the IDLE cycle after done
        @(negedge clk);
        A = 256'd5; B = 256'd3; start = 1'b1;
        ndone = 0; first_done = 0; second_done = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 10) check("held_idle_gap", 256'(busy), 256'd0);
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = c; else second_done = c;
            end
        end
        start = 1'b0;
        check("held_ndone", 256'(ndone), 256'd2);
        check("held_first", 256'(first_done), 256'd9);
        check("held_second", 256'(second_done), 256'd19);
        for (int c = 0; c < 40 && (busy || done); c++) @(negedge clk);
        @(negedge clk);

        // asynchronous reset in the middle of FIX
        A = 256'd1; B = 256'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_in_fix", 256'(busy), 256'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", 256'(busy), 256'd0);
        check("mid_rst_done", 256'(done), 256'd0);
        check("mid_rst_R", R, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("mid_rst_quiet", 256'(ndone), 256'd0);
        run_op(256'd7, 256'd7, res, lat, hs_ok);
        check("post_rst_R", res, 256'd0);
        check("post_rst_lat", 256'(lat), 256'd9);

        for (int n = 0; n < 200; n++) begin
            ra = rand_fe();
            rb = (n % 4 == 0) ? ra : rand_fe();
            golden = ra >= rb ? ra - rb : ra - rb + P;
            run_op(ra, rb, res, lat, hs_ok);
            check($sformatf("rand%0d_R", n), res, golden);
            check($sformatf("rand%0d_lat", n), 256'(lat), ra < rb ? 256'd17 : 256'd9);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
